// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing defaults and shared types.
// Imported by the timing generator, its delay line and its interface.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_H_TOTAL   =
    DEF_H_VISIBLE + DEF_H_FRONT +
    DEF_H_SYNC + DEF_H_BACK;

  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_V_TOTAL   =
    DEF_V_VISIBLE + DEF_V_FRONT +
    DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_HS_START =
    DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int unsigned DEF_HS_END   =
    DEF_HS_START + DEF_H_SYNC - 1;
  localparam int unsigned DEF_VS_START =
    DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int unsigned DEF_VS_END   =
    DEF_VS_START + DEF_V_SYNC - 1;

  localparam int DEF_BLANK_DLY = 1;
  localparam int DEF_SYNC_DLY  = 2;

  localparam int unsigned CW = 10;

  typedef logic [CW-1:0] coord_t;
  typedef logic [7:0]    fcnt_t;

  function automatic logic in_win(
    input coord_t v,
    input coord_t lo,
    input coord_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Timing bundle from the generator to mappers and the VGA pins.
// master drives, slave observes.
interface vga_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   line_start;
  logic   frame_start;
  fcnt_t  frame_cnt;

  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs,
    output vs,
    output line_start,
    output frame_start,
    output frame_cnt
  );

  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs,
    input vs,
    input line_start,
    input frame_start,
    input frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Fixed-depth shift register with async reset to a per-bit value.
// DEPTH 0 is a plain wire.
module vga_sync_delay #(
  parameter int                WIDTH   = 1,
  parameter int                DEPTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++)
          sr_q[i] <= RST_VAL;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++)
          sr_q[i] <= sr_q[i-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster counters, sync/blank decode and frame strobes.
// hs/vs/blank are delayed to line up with the mapper pipeline.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter int          BLANK_DLY = DEF_BLANK_DLY,
  parameter int          SYNC_DLY  = DEF_SYNC_DLY
) (
  input  logic  vga_clk,
  input  logic  reset_n,
  vga_if.master vga
);

  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
  localparam coord_t H_MAX   = coord_t'(
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_MAX   = coord_t'(
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t HS_S    = coord_t'(
    H_VISIBLE + H_FRONT);
  localparam coord_t HS_E    = coord_t'(
    H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_S    = coord_t'(
    V_VISIBLE + V_FRONT);
  localparam coord_t VS_E    = coord_t'(
    V_VISIBLE + V_FRONT + V_SYNC - 1);

  coord_t hc_q, hc_d;
  coord_t vc_q, vc_d;
  logic   ls_q, ls_d;
  logic   fs_q, fs_d;
  fcnt_t  fcnt_q, fcnt_d;

  logic       h_wrap;
  logic       v_wrap;
  logic       blank_raw;
  logic [1:0] sync_raw;
  logic [1:0] sync_dly;
  logic       blank_dly;

  always_comb begin
    h_wrap = (hc_q == H_MAX);
    v_wrap = (vc_q == V_MAX);
    hc_d   = hc_q + coord_t'(1);
    vc_d   = vc_q;
    unique case (1'b1)
      h_wrap && v_wrap: begin
        hc_d = '0;
        vc_d = '0;
      end
      h_wrap && !v_wrap: begin
        hc_d = '0;
        vc_d = vc_q + coord_t'(1);
      end
      !h_wrap: ;
      default: ;
    endcase
  end

  // Strobes come from the next-state wrap so they land on DrawX==0.
  always_comb begin
    ls_d   = h_wrap;
    fs_d   = h_wrap && v_wrap;
    fcnt_d = fcnt_q;
    if (fs_d)
      fcnt_d = fcnt_q + fcnt_t'(1);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q   <= '0;
      vc_q   <= '0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      hc_q   <= hc_d;
      vc_q   <= vc_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_comb begin
    blank_raw   = (hc_q < H_VIS_C) &&
                  (vc_q < V_VIS_C);
    sync_raw[1] = !in_win(hc_q, HS_S, HS_E);
    sync_raw[0] = !in_win(vc_q, VS_S, VS_E);
  end

  vga_sync_delay #(
    .WIDTH   (2),
    .DEPTH   (SYNC_DLY),
    .RST_VAL (2'b11)
  ) u_sync_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (sync_raw),
    .q_o    (sync_dly)
  );

  vga_sync_delay #(
    .WIDTH   (1),
    .DEPTH   (BLANK_DLY),
    .RST_VAL (1'b0)
  ) u_blank_dly (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    (blank_raw),
    .q_o    (blank_dly)
  );

  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.blank       = blank_dly;
  assign vga.hs          = sync_dly[1];
  assign vga.vs          = sync_dly[0];
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: u0 uses default 640x480 timing for one line,
// u1 a shrunken raster (20x10) for reset-mid-frame and 257 frames.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int x; int y; int len;
  } pulse_t;

  typedef struct {
    int x; int y; int gap;
    int fcnt; int bcnt; int aerr;
  } strobe_t;

  typedef struct {
    int x; int y; int blank; int hs;
    int vs; int ls; int fs; int fcnt;
  } snap_t;

  logic clk = 1'b0;
  logic rst0_n = 1'b0;
  logic rst1_n = 1'b0;

  always #5 clk = ~clk;

  vga_if if0 ();
  vga_if if1 ();

  vga_timing_gen u0 (
    .vga_clk (clk),
    .reset_n (rst0_n),
    .vga     (if0)
  );

  vga_timing_gen #(
    .H_VISIBLE (12), .H_FRONT (2),
    .H_SYNC    (3),  .H_BACK  (3),
    .V_VISIBLE (6),  .V_FRONT (1),
    .V_SYNC    (2),  .V_BACK  (1),
    .BLANK_DLY (2),  .SYNC_DLY (3)
  ) u1 (
    .vga_clk (clk),
    .reset_n (rst1_n),
    .vga     (if1)
  );

  int tests = 0;
  int fails = 0;

  snap_t   qs0[$], qs1[$];
  pulse_t  qh0[$], qh1[$], qv1[$];
  strobe_t ql0[$], qf1[$];

  localparam snap_t RST_SNAP =
    '{0, 0, 0, 1, 1, 0, 0, 0};

  task automatic chk(string n, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               n, act, exp);
    end
  endtask

  task automatic chk_snap(string t, snap_t a, snap_t e);
    chk({t, "_x"},     a.x,     e.x);
    chk({t, "_y"},     a.y,     e.y);
    chk({t, "_blank"}, a.blank, e.blank);
    chk({t, "_hs"},    a.hs,    e.hs);
    chk({t, "_vs"},    a.vs,    e.vs);
    chk({t, "_ls"},    a.ls,    e.ls);
    chk({t, "_fs"},    a.fs,    e.fs);
    chk({t, "_fcnt"},  a.fcnt,  e.fcnt);
  endtask

  // ---------------- monitor for u0 ----------------
  int     cnt0, bc0, ae0, x0, y0;
  logic   bh0, h0_in;
  pulse_t h0;

  always @(negedge clk) begin
    snap_t a0;
    x0 = int'(if0.DrawX);
    y0 = int'(if0.DrawY);
    if (qs0.size() > 0) begin
      a0 = '{x0, y0, int'(if0.blank),
             int'(if0.hs), int'(if0.vs),
             int'(if0.line_start),
             int'(if0.frame_start),
             int'(if0.frame_cnt)};
      chk_snap("d0_snap", a0, qs0.pop_front());
    end
    if (!rst0_n) begin
      cnt0 = 0; bc0 = 0; ae0 = 0;
      bh0 = 1'b1; h0_in = 1'b0;
    end else begin
      cnt0++;
      if (if0.line_start) begin
        if (ql0.size() == 0)
          chk("d0_ls_extra", ql0.size(), 1);
        else begin
          strobe_t e;
          e = ql0.pop_front();
          chk("d0_ls_gap",  cnt0, e.gap);
          chk("d0_ls_x",    x0,   e.x);
          chk("d0_ls_y",    y0,   e.y);
          chk("d0_ls_fcnt", int'(if0.frame_cnt), e.fcnt);
          chk("d0_ls_bcnt", bc0,  e.bcnt);
          chk("d0_ls_aerr", ae0,  e.aerr);
        end
        cnt0 = 0; bc0 = 0; ae0 = 0;
      end
      if (if0.blank !== bh0) ae0++;
      if (if0.line_start !== (x0 == 0)) ae0++;
      if (if0.frame_start !== (x0 == 0 && y0 == 0)) ae0++;
      if (if0.blank) bc0++;
      bh0 = (x0 < 640) && (y0 < 480);
      if (!if0.hs) begin
        if (!h0_in) begin
          h0_in = 1'b1;
          h0 = '{x0, y0, 0};
        end
        h0.len++;
      end else if (h0_in) begin
        h0_in = 1'b0;
        if (qh0.size() == 0)
          chk("d0_hs_extra", qh0.size(), 1);
        else begin
          pulse_t e;
          e = qh0.pop_front();
          chk("d0_hs_x",   h0.x,   e.x);
          chk("d0_hs_y",   h0.y,   e.y);
          chk("d0_hs_len", h0.len, e.len);
        end
      end
    end
  end

  // ---------------- monitor for u1 ----------------
  int     cnt1, last1, bc1, ae1, x1, y1;
  logic   bq0, bq1, h1_in, v1_in;
  pulse_t h1, v1;

  always @(negedge clk) begin
    snap_t a1;
    x1 = int'(if1.DrawX);
    y1 = int'(if1.DrawY);
    if (qs1.size() > 0) begin
      a1 = '{x1, y1, int'(if1.blank),
             int'(if1.hs), int'(if1.vs),
             int'(if1.line_start),
             int'(if1.frame_start),
             int'(if1.frame_cnt)};
      chk_snap("d1_snap", a1, qs1.pop_front());
    end
    if (!rst1_n) begin
      cnt1 = 0; last1 = -1; bc1 = 0; ae1 = 0;
      bq0 = 1'b1; bq1 = 1'b0;
      h1_in = 1'b0; v1_in = 1'b0;
    end else begin
      cnt1++;
      if (if1.frame_start) begin
        if (qf1.size() == 0)
          chk("d1_fs_extra", qf1.size(), 1);
        else begin
          strobe_t e;
          e = qf1.pop_front();
          chk("d1_fs_gap",
              (last1 < 0) ? cnt1 - 1 : cnt1 - last1,
              e.gap);
          chk("d1_fs_x",    x1,  e.x);
          chk("d1_fs_y",    y1,  e.y);
          chk("d1_fs_fcnt", int'(if1.frame_cnt), e.fcnt);
          chk("d1_fs_bcnt", bc1, e.bcnt);
          chk("d1_fs_aerr", ae1, e.aerr);
        end
        last1 = cnt1; bc1 = 0; ae1 = 0;
      end
      if (if1.blank !== bq1) ae1++;
      if (if1.line_start !== (x1 == 0)) ae1++;
      if (if1.frame_start !== (x1 == 0 && y1 == 0)) ae1++;
      if (if1.blank) bc1++;
      bq1 = bq0;
      bq0 = (x1 < 12) && (y1 < 6);
      if (!if1.hs) begin
        if (!h1_in) begin
          h1_in = 1'b1;
          h1 = '{x1, y1, 0};
        end
        h1.len++;
      end else if (h1_in) begin
        h1_in = 1'b0;
        if (qh1.size() == 0)
          chk("d1_hs_extra", qh1.size(), 1);
        else begin
          pulse_t e;
          e = qh1.pop_front();
          chk("d1_hs_x",   h1.x,   e.x);
          chk("d1_hs_y",   h1.y,   e.y);
          chk("d1_hs_len", h1.len, e.len);
        end
      end
      if (!if1.vs) begin
        if (!v1_in) begin
          v1_in = 1'b1;
          v1 = '{x1, y1, 0};
        end
        v1.len++;
      end else if (v1_in) begin
        v1_in = 1'b0;
        if (qv1.size() == 0)
          chk("d1_vs_extra", qv1.size(), 1);
        else begin
          pulse_t e;
          e = qv1.pop_front();
          chk("d1_vs_x",   v1.x,   e.x);
          chk("d1_vs_y",   v1.y,   e.y);
          chk("d1_vs_len", v1.len, e.len);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    fork
      begin : seq0
        repeat (5) @(posedge clk);
        #1 qs0.push_back(RST_SNAP);
        @(negedge clk);
        #2 rst0_n = 1'b1;
        qh0.push_back('{658, 0, 96});
        ql0.push_back('{0, 1, 800, 0, 640, 0});
        repeat (805) @(posedge clk);
        #2 rst0_n = 1'b0;
        chk("d0_hs_left", qh0.size(), 0);
        chk("d0_ls_left", ql0.size(), 0);
      end
      begin : seq1
        repeat (5) @(posedge clk);
        #1 qs1.push_back(RST_SNAP);
        @(negedge clk);
        #2 rst1_n = 1'b1;
        for (int l = 0; l < 8; l++)
          qh1.push_back('{17, l, 3});
        repeat (178) @(posedge clk);
        #1 qs1.push_back('{18, 8, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        #1 rst1_n = 1'b0;
        #1 qs1.push_back(RST_SNAP);
        repeat (3) @(negedge clk);
        #2 rst1_n = 1'b1;
        for (int k = 0; k < 257; k++) begin
          for (int l = 0; l < 10; l++)
            qh1.push_back('{17, l, 3});
          qv1.push_back('{3, 7, 40});
          qf1.push_back('{0, 0, (k == 0) ? 199 : 200,
                          (k + 1) % 256, 72, 0});
        end
        for (int i = 0; i < 60000 && qf1.size() != 0; i++)
          @(posedge clk);
        #2 rst1_n = 1'b0;
        chk("d1_fs_left", qf1.size(), 0);
        chk("d1_hs_left", qh1.size(), 0);
        chk("d1_vs_left", qv1.size(), 0);
      end
    join
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
